mcdf_pkt_formatter: RTL

//  Parametrised store-and-forward packet formatter for the MCDF datapath. Sits after the

---
 rtl/mcdf_fmt_pkg.sv | 34 +++
 rtl/mcdf_fmt_sync_fifo.sv | 45 ++++
 rtl/mcdf_pkt_formatter.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/mcdf_fmt_pkg.sv
// rtl/mcdf_fmt_pkg.sv - shared types and length decode for the MCDF packet formatter
package mcdf_fmt_pkg;

   typedef enum logic {
      IN_IDLE,
      IN_COLLECT
   } in_fsm_e;

   typedef enum logic [1:0] {
      O_IDLE,
      O_REQ,
      O_SEND
   } out_fsm_e;

   localparam logic [1:0] LEN_CODE_4  = 2'd0;
   localparam logic [1:0] LEN_CODE_8  = 2'd1;
   localparam logic [1:0] LEN_CODE_16 = 2'd2;
   localparam logic [1:0] LEN_CODE_32 = 2'd3;

   // Word count for a length code, clamped so a packet never exceeds one slot.
   function automatic int decode_len(input logic [1:0] code, input int max_len);
      int l;
      case (code)
         LEN_CODE_4:  l = 4;
         LEN_CODE_8:  l = 8;
         LEN_CODE_16: l = 16;
         LEN_CODE_32: l = 32;
         default:     l = 32;
      endcase
      if (l > max_len) l = max_len;
      return l;
   endfunction

endpackage

// File: rtl/mcdf_fmt_sync_fifo.sv
// rtl/mcdf_fmt_sync_fifo.sv - word buffer with show-ahead read and occupancy count
module mcdf_fmt_sync_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 64
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       wr_en,
   input  logic [WIDTH-1:0]           wr_data,
   input  logic                       rd_en,
   output logic [WIDTH-1:0]           rd_data,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;

   // Depth need not be a power of two, so pointers wrap explicitly.
   function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
      return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
   endfunction

   assign rd_data = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr] <= wr_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_en) wr_ptr <= ptr_inc(wr_ptr);
         if (rd_en) rd_ptr <= ptr_inc(rd_ptr);
         count <= count + CW'(wr_en) - CW'(rd_en);
      end
   end

endmodule

// File: rtl/mcdf_pkt_formatter.sv
// rtl/mcdf_pkt_formatter.sv - store-and-forward packet formatter with grant-based output framing
module mcdf_pkt_formatter
   import mcdf_fmt_pkg::*;
#(
   parameter  int DATA_WIDTH = 32,
   parameter  int CH_NUM     = 3,
   parameter  int MAX_LEN    = 32,
   parameter  int PKT_SLOTS  = 2,
   localparam int CHID_W     = ($clog2(CH_NUM) > 1) ? $clog2(CH_NUM) : 1,
   localparam int LEN_W      = $clog2(MAX_LEN) + 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [CHID_W-1:0]     in_chid,
   input  logic [1:0]            in_len,
   input  logic [DATA_WIDTH-1:0] in_data,
   output logic                  fmt_req,
   input  logic                  fmt_grant,
   output logic [CHID_W-1:0]     fmt_chid,
   output logic [LEN_W-1:0]      fmt_length,
   output logic                  fmt_start,
   output logic                  fmt_end,
   output logic [DATA_WIDTH-1:0] fmt_data,
   output logic                  idle
);

   localparam int DEPTH = PKT_SLOTS * MAX_LEN;
   localparam int CW    = $clog2(DEPTH + 1);
   localparam int SW    = (PKT_SLOTS > 1) ? $clog2(PKT_SLOTS) : 1;
   localparam int QW    = $clog2(PKT_SLOTS + 1);

   in_fsm_e  in_state, in_state_d;
   out_fsm_e out_state, out_state_d;

   logic                  run_q;
   logic [CHID_W-1:0]     cur_chid_q;
   logic [LEN_W-1:0]      cur_len_q;
   logic [LEN_W-1:0]      in_cnt_q;
   logic [CW-1:0]         reserved_q;
   logic [CW-1:0]         free_words;
   logic [LEN_W-1:0]      dec_len;
   logic                  in_fire, first_fire, last_fire;

   logic [CHID_W-1:0]     desc_chid [PKT_SLOTS];
   logic [LEN_W-1:0]      desc_len  [PKT_SLOTS];
   logic [SW-1:0]         desc_wr, desc_rd;
   logic [QW-1:0]         desc_cnt;
   logic                  desc_pop;

   logic                  fifo_rd;
   logic [DATA_WIDTH-1:0] fifo_rdata;
   logic [CW-1:0]         fifo_count;

   logic                  fmt_req_d, fmt_start_d, fmt_end_d;
   logic [CHID_W-1:0]     fmt_chid_d;
   logic [LEN_W-1:0]      fmt_length_d, beat_q, beat_d;
   logic [DATA_WIDTH-1:0] fmt_data_d;

   function automatic logic [SW-1:0] slot_inc(input logic [SW-1:0] p);
      return (p == SW'(PKT_SLOTS - 1)) ? '0 : p + SW'(1);
   endfunction

   assign dec_len    = LEN_W'(decode_len(in_len, MAX_LEN));
   assign free_words = CW'(DEPTH) - reserved_q;
   assign in_fire    = in_valid & in_ready;

   // run_q keeps in_ready and idle low while reset is asserted.
   always_comb begin
      in_state_d = in_state;
      in_ready   = 1'b0;
      first_fire = 1'b0;
      last_fire  = 1'b0;
      case (in_state)
         IN_IDLE: begin
            in_ready = run_q && (free_words >= CW'(dec_len)) && (desc_cnt != QW'(PKT_SLOTS));
            if (in_valid && in_ready) begin
               first_fire = 1'b1;
               in_state_d = IN_COLLECT;
            end
         end
         IN_COLLECT: begin
            in_ready = 1'b1;
            if (in_valid && (in_cnt_q + LEN_W'(1) == cur_len_q)) begin
               last_fire  = 1'b1;
               in_state_d = IN_IDLE;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         in_state   <= IN_IDLE;
         run_q      <= 1'b0;
         cur_chid_q <= '0;
         cur_len_q  <= '0;
         in_cnt_q   <= '0;
         reserved_q <= '0;
         desc_wr    <= '0;
         desc_rd    <= '0;
         desc_cnt   <= '0;
      end else begin
         in_state <= in_state_d;
         run_q    <= 1'b1;
         if (first_fire) begin
            cur_chid_q <= in_chid;
            cur_len_q  <= dec_len;
            in_cnt_q   <= LEN_W'(1);
         end else if (in_fire) begin
            in_cnt_q <= in_cnt_q + LEN_W'(1);
         end
         // Space is claimed for the whole packet up front and handed back one word per beat.
         reserved_q <= reserved_q + (first_fire ? CW'(dec_len) : '0) - CW'(fifo_rd);
         if (last_fire) desc_wr <= slot_inc(desc_wr);
         if (desc_pop)  desc_rd <= slot_inc(desc_rd);
         desc_cnt <= desc_cnt + QW'(last_fire) - QW'(desc_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (last_fire) begin
         desc_chid[desc_wr] <= cur_chid_q;
         desc_len[desc_wr]  <= cur_len_q;
      end
   end

   mcdf_fmt_sync_fifo #(
      .WIDTH (DATA_WIDTH),
      .DEPTH (DEPTH)
   ) u_word_buf (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (in_fire),
      .wr_data (in_data),
      .rd_en   (fifo_rd),
      .rd_data (fifo_rdata),
      .count   (fifo_count)
   );

   always_comb begin
      out_state_d  = out_state;
      fmt_req_d    = fmt_req;
      fmt_chid_d   = fmt_chid;
      fmt_length_d = fmt_length;
      fmt_start_d  = 1'b0;
      fmt_end_d    = 1'b0;
      fmt_data_d   = '0;
      beat_d       = beat_q;
      fifo_rd      = 1'b0;
      desc_pop     = 1'b0;
      case (out_state)
         O_IDLE: begin
            if (desc_cnt != '0) begin
               out_state_d  = O_REQ;
               fmt_req_d    = 1'b1;
               fmt_chid_d   = desc_chid[desc_rd];
               fmt_length_d = desc_len[desc_rd];
            end
         end
         O_REQ: begin
            if (fmt_grant) begin
               out_state_d = O_SEND;
               fmt_req_d   = 1'b0;
               fifo_rd     = 1'b1;
               fmt_data_d  = fifo_rdata;
               fmt_start_d = 1'b1;
               beat_d      = LEN_W'(1);
            end
         end
         O_SEND: begin
            if (beat_q != fmt_length) begin
               fifo_rd    = 1'b1;
               fmt_data_d = fifo_rdata;
               beat_d     = beat_q + LEN_W'(1);
               fmt_end_d  = (beat_q + LEN_W'(1) == fmt_length);
            end else begin
               // Descriptor is retired one cycle after the last beat, leaving a bubble.
               out_state_d  = O_IDLE;
               desc_pop     = 1'b1;
               fmt_chid_d   = '0;
               fmt_length_d = '0;
               beat_d       = '0;
            end
         end
         default: out_state_d = O_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_state  <= O_IDLE;
         fmt_req    <= 1'b0;
         fmt_chid   <= '0;
         fmt_length <= '0;
         fmt_start  <= 1'b0;
         fmt_end    <= 1'b0;
         fmt_data   <= '0;
         beat_q     <= '0;
      end else begin
         out_state  <= out_state_d;
         fmt_req    <= fmt_req_d;
         fmt_chid   <= fmt_chid_d;
         fmt_length <= fmt_length_d;
         fmt_start  <= fmt_start_d;
         fmt_end    <= fmt_end_d;
         fmt_data   <= fmt_data_d;
         beat_q     <= beat_d;
      end
   end

   assign idle = run_q && (in_state == IN_IDLE) && (out_state == O_IDLE) &&
                 (desc_cnt == '0) && (reserved_q == '0) && (fifo_count == '0);

endmodule
